// File: rtl/ddr3_mem_responder.sv
// Memory-side DDR3 pin responder: decodes controller commands, tracks open banks and
// serves one BL4 single-data-rate burst at a time from a small on-chip RAM.
module ddr3_mem_responder #(
  parameter int unsigned COL_W = 7,
  parameter int unsigned CL    = 5,
  parameter int unsigned WL    = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] mem_a,
  input  logic [2:0]  mem_ba,
  input  logic        mem_cke,
  input  logic        mem_cs_n,
  input  logic        mem_ras_n,
  input  logic        mem_cas_n,
  input  logic        mem_we_n,
  input  logic        mem_reset_n,
  input  logic        mem_odt,
  input  logic        mem_dm,
  input  logic [7:0]  dq_in,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        dqs_out,
  output logic        dqs_oe,
  output logic [7:0]  bank_open,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned AW    = 3 + COL_W;
  localparam int unsigned DEPTH = 8 << COL_W;

  typedef enum logic [1:0] {IDLE, WAIT_LAT, BEATS} state_t;

  state_t              state_q;
  logic [3:0]          lat_q;
  logic [1:0]          beat_q;
  logic [2:0]          b_ba_q;
  logic [COL_W-1:0]    b_col_q;
  logic                b_rd_q, b_ap_q;
  logic                busy_q, dq_oe_q, dqs_oe_q, dqs_out_q;
  logic [7:0]          dq_out_q, bank_open_q, err_q;
  logic [7:0][12:0]    rows_q;
  logic [7:0]          mem [DEPTH];

  // device reset from either source; only the fabric reset clears the error counter
  logic dev_rst;
  assign dev_rst = reset_reset | ~mem_reset_n;

  logic       cmd_v;
  logic [2:0] cmd;
  logic       is_act, is_rd, is_wr, is_pre, is_ref;
  assign cmd_v  = mem_cke & ~mem_cs_n & mem_reset_n;
  assign cmd    = {mem_ras_n, mem_cas_n, mem_we_n};
  assign is_act = cmd_v && cmd == 3'b011;
  assign is_rd  = cmd_v && cmd == 3'b101;
  assign is_wr  = cmd_v && cmd == 3'b100;
  assign is_pre = cmd_v && cmd == 3'b010;
  assign is_ref = cmd_v && cmd == 3'b001;

  logic bank_hit, burst_bank, act_ok, pre_ok, rw_ok, err;
  assign bank_hit   = bank_open_q[mem_ba];
  assign burst_bank = busy_q && (mem_a[10] ? is_pre : 1'b1) && (mem_a[10] && is_pre || mem_ba == b_ba_q);
  assign act_ok     = is_act && !bank_hit && !burst_bank;
  assign pre_ok     = is_pre && !burst_bank;
  assign rw_ok      = (is_rd || is_wr) && bank_hit && !busy_q;
  assign err = (is_act && !act_ok) || (is_pre && !pre_ok) || ((is_rd || is_wr) && !rw_ok)
            || (is_ref && |bank_open_q);

  // beat 0 fires on the last latency tick; beats 1..3 walk beat_q, beat_q==0 in BEATS ends the burst
  logic          beat_go;
  logic [1:0]    beat_idx, beat_lo;
  logic [AW-1:0] beat_addr;
  assign beat_go   = (state_q == WAIT_LAT && lat_q == 4'd0) || (state_q == BEATS && beat_q != 2'd0);
  assign beat_idx  = (state_q == BEATS) ? beat_q : 2'd0;
  assign beat_lo   = b_col_q[1:0] + beat_idx;
  assign beat_addr = {b_ba_q, b_col_q[COL_W-1:2], beat_lo};

  always_ff @(posedge clk_clk) begin
    if (!dev_rst && beat_go && !b_rd_q && !mem_dm) mem[beat_addr] <= dq_in;
  end

  always_ff @(posedge clk_clk) begin
    if (dev_rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      b_ba_q      <= '0;
      b_col_q     <= '0;
      b_rd_q      <= 1'b0;
      b_ap_q      <= 1'b0;
      busy_q      <= 1'b0;
      dq_oe_q     <= 1'b0;
      dqs_oe_q    <= 1'b0;
      dqs_out_q   <= 1'b0;
      dq_out_q    <= '0;
      bank_open_q <= '0;
    end else begin
      if (act_ok) begin
        bank_open_q[mem_ba] <= 1'b1;
        rows_q[mem_ba]      <= mem_a;
      end
      if (pre_ok) begin
        if (mem_a[10]) bank_open_q <= '0;
        else           bank_open_q[mem_ba] <= 1'b0;
      end
      case (state_q)
        IDLE: if (rw_ok) begin
          state_q <= WAIT_LAT;
          busy_q  <= 1'b1;
          lat_q   <= is_rd ? 4'(CL - 1) : 4'(WL - 1);
          b_ba_q  <= mem_ba;
          b_col_q <= mem_a[COL_W-1:0];
          b_rd_q  <= is_rd;
          b_ap_q  <= mem_a[10];
        end
        WAIT_LAT: begin
          if (lat_q == 4'd0) begin
            state_q <= BEATS;
            beat_q  <= 2'd1;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
          if (lat_q == 4'd1 && b_rd_q) begin
            dqs_oe_q  <= 1'b1;
            dqs_out_q <= 1'b0;
          end
        end
        BEATS: begin
          if (beat_q == 2'd0) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            dq_oe_q   <= 1'b0;
            dqs_oe_q  <= 1'b0;
            dqs_out_q <= 1'b0;
            dq_out_q  <= '0;
            if (b_ap_q) bank_open_q[b_ba_q] <= 1'b0;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (beat_go && b_rd_q) begin
        dq_oe_q   <= 1'b1;
        dqs_oe_q  <= 1'b1;
        dqs_out_q <= ~beat_idx[0];
        dq_out_q  <= mem[beat_addr];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)                 err_q <= '0;
    else if (err && err_q != 8'hFF)  err_q <= err_q + 8'd1;
  end

  // rows alias in storage; the latched row and unused pins are kept only for observability
  logic unused_sig;
  assign unused_sig = ^{mem_odt, mem_a, rows_q};

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_out   = dqs_out_q;
  assign dqs_oe    = dqs_oe_q;
  assign bank_open = bank_open_q;
  assign busy      = busy_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ddr3_mem_responder.sv
// Directed bench for ddr3_mem_responder: model memory plus a queue of expected read beats.
module tb_ddr3_mem_responder;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [12:0] mem_a = '0;
  logic [2:0]  mem_ba = '0;
  logic        mem_cke = 1'b1, mem_cs_n = 1'b1, mem_ras_n = 1'b1, mem_cas_n = 1'b1, mem_we_n = 1'b1;
  logic        mem_reset_n = 1'b1, mem_odt = 1'b0, mem_dm = 1'b0;
  logic [7:0]  dq_in = '0;
  logic [7:0]  dq_out, bank_open, err_count;
  logic        dq_oe, dqs_out, dqs_oe, busy;

  ddr3_mem_responder #(.COL_W(7), .CL(5), .WL(4)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .mem_a(mem_a), .mem_ba(mem_ba),
    .mem_cke(mem_cke), .mem_cs_n(mem_cs_n), .mem_ras_n(mem_ras_n), .mem_cas_n(mem_cas_n),
    .mem_we_n(mem_we_n), .mem_reset_n(mem_reset_n), .mem_odt(mem_odt), .mem_dm(mem_dm),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .dqs_out(dqs_out), .dqs_oe(dqs_oe),
    .bank_open(bank_open), .busy(busy), .err_count(err_count)
  );

  always #5 clk_clk = ~clk_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl [1024];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_err = '0;

  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk); #1;
  endtask

  task automatic drive(input logic [2:0] c3, input logic [2:0] ba, input logic [12:0] a);
    {mem_ras_n, mem_cas_n, mem_we_n} = c3;
    mem_ba = ba; mem_a = a; mem_cs_n = 1'b0;
  endtask

  task automatic nop();
    mem_cs_n = 1'b1; {mem_ras_n, mem_cas_n, mem_we_n} = 3'b111;
  endtask

  task automatic issue(input logic [2:0] c3, input logic [2:0] ba, input logic [12:0] a);
    drive(c3, ba, a); tick(); nop();
  endtask

  function automatic logic [9:0] baddr(input logic [2:0] ba, input logic [6:0] col, input int i);
    logic [1:0] lo;
    lo = 2'(col[1:0] + 2'(i));
    return {ba, col[6:2], lo};
  endfunction

  task automatic write_burst(input logic [2:0] ba, input logic [6:0] col,
                             input logic [31:0] data, input logic [3:0] dm);
    for (int i = 0; i < 4; i++) if (!dm[i]) mdl[baddr(ba, col, i)] = data[8*i +: 8];
    issue(C_WR, ba, {6'b0, col});
    chk("wr_busy_rise", busy, 1);
    for (int c = 1; c <= 3; c++) tick();
    for (int i = 0; i < 4; i++) begin
      dq_in = data[8*i +: 8]; mem_dm = dm[i];
      tick();
      chk("wr_no_dq_oe", dq_oe, 0);
    end
    mem_dm = 1'b0; dq_in = '0;
    chk("wr_busy_last", busy, 1);
    tick();
    chk("wr_busy_fall", busy, 0);
  endtask

  // abort: 0 none, 1 reset_reset at beat 1, 2 mem_reset_n at beat 1
  task automatic read_burst(input logic [2:0] ba, input logic [6:0] col, input bit ap,
                            input bit collide, input int abort);
    for (int i = 0; i < 4; i++) exp_q.push_back(mdl[baddr(ba, col, i)]);
    issue(C_RD, ba, {2'b0, ap, 3'b0, col});
    chk("rd_busy_rise", busy, 1);
    for (int c = 1; c <= 9; c++) begin
      if (collide && c == 2) drive(C_RD, ba, 13'h0);
      if (abort == 1 && c == 7) reset_reset = 1'b1;
      if (abort == 2 && c == 7) mem_reset_n = 1'b0;
      tick(); nop();
      if (abort != 0 && c == 7) begin
        if (abort == 1) exp_err = '0;
        chk("abort_dq_oe", dq_oe, 0);
        chk("abort_dqs_oe", dqs_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bank_open", bank_open, 0);
        chk("abort_err", err_count, exp_err);
        reset_reset = 1'b0; mem_reset_n = 1'b1;
        exp_q.delete();
        tick();
        return;
      end
      if (c <= 3) begin
        chk("rd_pre_idle", {dq_oe, dqs_oe}, 0);
      end else if (c == 4) begin
        chk("rd_preamble", {dq_oe, dqs_oe, dqs_out}, 3'b010);
      end else if (c <= 8) begin
        chk("rd_oe", {dq_oe, dqs_oe}, 2'b11);
        chk("rd_dqs", dqs_out, (c == 5 || c == 7) ? 1 : 0);
        if (exp_q.size() == 0) chk("rd_queue_underflow", 1, 0);
        else chk("rd_data", dq_out, exp_q.pop_front());
        if (c == 8) chk("rd_bank_still_open", bank_open[ba], 1);
        if (c == 8) chk("rd_busy_last", busy, 1);
      end else begin
        chk("rd_drives_off", {dq_oe, dqs_oe, busy}, 0);
        chk("rd_ap_bank", bank_open[ba], ap ? 0 : 1);
      end
    end
    chk("rd_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    reset_reset = 1'b0;
    chk("rst_outputs", {dq_out, dq_oe, dqs_out, dqs_oe, busy}, 0);
    chk("rst_bank_open", bank_open, 0);
    chk("rst_err", err_count, 0);

    // basic write then read on bank 2
    issue(C_ACT, 3'd2, 13'h55);
    chk("act_bank2", bank_open, 8'h04);
    write_burst(3'd2, 7'h10, 32'hA4A3A2A1, 4'b0000);
    read_burst(3'd2, 7'h10, 1'b0, 1'b0, 0);
    chk("t1_err", err_count, exp_err);

    // wrapped write with beat 1 masked
    write_burst(3'd2, 7'h12, 32'hB4B3B2B1, 4'b0010);
    read_burst(3'd2, 7'h10, 1'b0, 1'b0, 0);
    chk("t2_err", err_count, exp_err);

    // closed-bank read and double ACT
    issue(C_PRE, 3'd0, 13'h400);
    chk("pre_all", bank_open, 0);
    issue(C_RD, 3'd5, 13'h0); exp_err++;
    for (int c = 0; c < 10; c++) begin
      chk("closed_rd_quiet", {dq_oe, dqs_oe, busy}, 0);
      tick();
    end
    issue(C_ACT, 3'd1, 13'h1);
    issue(C_ACT, 3'd1, 13'h2); exp_err++;
    chk("t3_err", err_count, exp_err);
    chk("t3_bank_open", bank_open, 8'h02);

    // auto-precharge read with a colliding READ while busy
    issue(C_ACT, 3'd3, 13'h7);
    write_burst(3'd3, 7'h21, 32'h44332211, 4'b0000);
    exp_err++;
    read_burst(3'd3, 7'h21, 1'b1, 1'b1, 0);
    chk("t4_err", err_count, exp_err);
    chk("t4_bank_open", bank_open, 8'h02);

    // precharge-all and refresh rules
    issue(C_PRE, 3'd0, 13'h400);
    issue(C_ACT, 3'd0, 13'h0);
    issue(C_ACT, 3'd4, 13'h0);
    chk("t5_two_open", bank_open, 8'h11);
    issue(C_PRE, 3'd6, 13'h400);
    chk("t5_pre_all", bank_open, 0);
    issue(C_REF, 3'd0, 13'h0);
    chk("t5_ref_ok", err_count, exp_err);
    issue(C_ACT, 3'd0, 13'h0);
    issue(C_REF, 3'd0, 13'h0); exp_err++;
    chk("t5_ref_err", err_count, exp_err);

    // fabric reset mid-burst clears everything including err_count
    write_burst(3'd0, 7'h30, 32'hD4D3D2D1, 4'b0000);
    read_burst(3'd0, 7'h30, 1'b0, 1'b0, 1);
    chk("t6_err_cleared", err_count, 0);

    // device reset mid-burst keeps err_count
    issue(C_ACT, 3'd0, 13'h0);
    issue(C_ACT, 3'd0, 13'h0); exp_err++;
    chk("t6_err_one", err_count, exp_err);
    read_burst(3'd0, 7'h30, 1'b0, 1'b0, 2);
    chk("t6_err_kept", err_count, exp_err);

    // storage survives resets
    issue(C_ACT, 3'd0, 13'h0);
    read_burst(3'd0, 7'h32, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
